cordic_scale_arbiter: RTL

- Shares one pipelined CORDIC gain-compensation scaler (K ≈ 0.60724, CSD shift-add) among NREQ rotation engines of the Givens-rotation QR array.
- Each engine submits an (x, y) pair and receives both components scaled by K, tagged with the requester index.
- Round-robin arbitration, valid/ready handshakes on both sides, 2-stage pipeline with full-stall backpressure.

---
 rtl/cordic_scale_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cordic_scale_arbiter.sv
// cordic_scale_arbiter
//
// Shares one pipelined CORDIC gain-compensation scaler (K ~= 0.60724) among
// NREQ rotation engines. Each engine offers an (x, y) pair and gets back
// K*x and K*y, tagged with its own index.
//
// K is applied as a CSD shift-add:
//   K*v ~= ((v>>>1) + (v>>>3)) - ((v>>>6) + (v>>>9)) - ((v>>>12) - (v>>>14))
// Stage 1 registers the three partial sums, and stage 2 registers the final
// difference. Every sum is DATA_W bits, two's complement and wrapping.
//
// Optional build macro: CSD_ROUND_EN
//   undefined : each term v>>>k truncates toward -inf
//   defined   : each term is (v + 2^(k-1))>>>k (round half up, wrapping add)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req_valid  [NREQ]        requester i presents data
//   req_ready  [NREQ]        requester i granted this cycle (one-hot or zero)
//   req_x/y    [NREQ*DATA_W] packed operands, requester i at [i*DATA_W +: DATA_W]
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_x/y    [DATA_W]      K*x, K*y
//   out_id     [ID_W]        originating requester index
//   busy       any pipeline stage holds valid data
module cordic_scale_arbiter #(
    parameter int DATA_W = 17,
    parameter int NREQ   = 4,
    parameter int ID_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*DATA_W-1:0]   req_x,
    input  logic [NREQ*DATA_W-1:0]   req_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_x,
    output logic [DATA_W-1:0]        out_y,
    output logic [ID_W-1:0]          out_id,
    output logic                     busy
);

    typedef logic signed [DATA_W-1:0] word_t;

    typedef struct packed {
        word_t a;
        word_t b;
        word_t c;
    } part_t;

    // (base + offs) mod NREQ, with offs in 0..NREQ
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return ID_W'(s);
    endfunction

    function automatic word_t shr(input word_t v, input int k);
`ifdef CSD_ROUND_EN
        word_t bias;
        word_t r;
        bias = word_t'(1) << (k - 1);
        r    = v + bias;
        return r >>> k;
`else
        return v >>> k;
`endif
    endfunction

    function automatic part_t partials(input word_t v);
        part_t p;
        p.a = shr(v, 1)  + shr(v, 3);
        p.b = shr(v, 6)  + shr(v, 9);
        p.c = shr(v, 12) - shr(v, 14);
        return p;
    endfunction

    function automatic word_t combine(input part_t p);
        return p.a - p.b - p.c;
    endfunction

    logic             en;
    logic [ID_W-1:0]  ptr;
    logic             xfer;
    logic [ID_W-1:0]  xfer_id;
    word_t            sel_x;
    word_t            sel_y;

    logic             s1_valid;
    logic [ID_W-1:0]  s1_id;
    part_t            s1_px;
    part_t            s1_py;

    // The whole pipeline moves as one. A held result blocks every stage, and
    // so it also blocks new grants.
    assign en   = !out_valid || out_ready;
    assign busy = s1_valid || out_valid;

    // Round-robin search from ptr. The grant is qualified by req_valid, so a
    // set req_ready bit always means a transfer in this cycle.
    always_comb begin
        req_ready = '0;
        xfer      = 1'b0;
        xfer_id   = '0;
        if (en && !rst) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!xfer && req_valid[wrap_idx(ptr, k)]) begin
                    xfer    = 1'b1;
                    xfer_id = wrap_idx(ptr, k);
                end
            end
            req_ready[xfer_id] = xfer;
        end
    end

    assign sel_x = req_x[int'(xfer_id)*DATA_W +: DATA_W];
    assign sel_y = req_y[int'(xfer_id)*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= wrap_idx(xfer_id, 1);
        end
    end

    // Bubbles still pass through both stages, so each data register loads on
    // every enabled edge whether or not its valid bit is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_id     <= '0;
            s1_px     <= '0;
            s1_py     <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_x     <= '0;
            out_y     <= '0;
        end else if (en) begin
            s1_valid  <= xfer;
            s1_id     <= xfer_id;
            s1_px     <= partials(sel_x);
            s1_py     <= partials(sel_y);
            out_valid <= s1_valid;
            out_id    <= s1_id;
            out_x     <= combine(s1_px);
            out_y     <= combine(s1_py);
        end
    end

endmodule
